// File: rtl/dbus_sram_responder_if.sv
// Data-bus request/response types and the handshake interface between the
// CPU memory stage (master) and a memory-side responder (slave).
package dbus_pkg;
  typedef enum logic [2:0] {
    MSIZE1 = 3'd0,
    MSIZE2 = 3'd1,
    MSIZE4 = 3'd2
  } msize_t;

  typedef struct packed {
    logic        valid;
    logic [31:0] addr;
    msize_t      size;
    logic [3:0]  strobe;
    logic [31:0] data;
  } dbus_req_t;

  typedef struct packed {
    logic        addr_ok;
    logic        data_ok;
    logic [31:0] data;
  } dbus_resp_t;
endpackage

interface dbus_sram_responder_if;
  import dbus_pkg::*;
  dbus_req_t  dreq;
  dbus_resp_t dresp;

  modport master (output dreq, input dresp);
  modport slave  (input dreq, output dresp);
endinterface

// File: rtl/dbus_sram_responder.sv
// Single-outstanding SRAM responder with fixed accept->data_ok latency.
// Optional DBUS_ALIGN_CHECK_EN: flags misaligned accesses and suppresses them.
module dbus_sram_responder
  import dbus_pkg::*;
#(
  parameter int DEPTH   = 1024,
  parameter int LATENCY = 2
) (
  input  logic                   clk,
  input  logic                   resetn,
  dbus_sram_responder_if.slave   bus,
  output logic                   align_err
);
  localparam int IW = $clog2(DEPTH);
  localparam logic [3:0] CNT_INIT = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t          state_q, state_d;
  logic [3:0]      cnt_q, cnt_d;
  logic [IW-1:0]   idx_q;
  logic [3:0]      strb_q;
  logic [31:0]     wdata_q;
  logic            wr_q;
  logic            mis_q, mis_d;
  logic            accept;
  dbus_resp_t      resp;
  logic [31:0]     mem [DEPTH];
  logic            unused_bits;

  // Gating with resetn keeps addr_ok low while reset is held.
  assign accept = (state_q == IDLE) && bus.dreq.valid && resetn;

`ifdef DBUS_ALIGN_CHECK_EN
  assign mis_d = ((bus.dreq.size == MSIZE2) && bus.dreq.addr[0]) ||
                 ((bus.dreq.size == MSIZE4) && (bus.dreq.addr[1:0] != 2'b00));
`else
  assign mis_d = 1'b0;
`endif

  assign unused_bits = ^{bus.dreq.addr[31:IW+2], bus.dreq.addr[1:0], bus.dreq.size};

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      idx_q   <= '0;
      strb_q  <= 4'd0;
      wdata_q <= 32'd0;
      wr_q    <= 1'b0;
      mis_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        idx_q   <= bus.dreq.addr[IW+1:2];
        strb_q  <= bus.dreq.strobe;
        wdata_q <= bus.dreq.data;
        wr_q    <= (bus.dreq.strobe != 4'd0);
        mis_q   <= mis_d;
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    resp.addr_ok = 1'b0;
    resp.data_ok = 1'b0;
    resp.data    = 32'd0;
    case (state_q)
      IDLE: begin
        resp.addr_ok = accept;
        if (accept) begin
          if (LATENCY > 0) begin
            state_d = WAIT;
            cnt_d   = CNT_INIT;
          end else begin
            state_d = RESP;
          end
        end
      end
      WAIT: begin
        if (cnt_q == 4'd0) state_d = RESP;
        else               cnt_d   = cnt_q - 4'd1;
      end
      RESP: begin
        resp.data_ok = 1'b1;
        if (!wr_q) resp.data = mis_q ? 32'hDEAD_BEEF : mem[idx_q];
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.dresp = resp;

  // Write commits on the RESP edge; reset forces IDLE so aborted writes never land.
  always_ff @(posedge clk) begin
    if (state_q == RESP && wr_q && !mis_q) begin
      for (int i = 0; i < 4; i++)
        if (strb_q[i]) mem[idx_q][8*i +: 8] <= wdata_q[8*i +: 8];
    end
  end

`ifdef DBUS_ALIGN_CHECK_EN
  logic align_err_q;
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)                             align_err_q <= 1'b0;
    else if (state_q == RESP && mis_q)       align_err_q <= 1'b1;
  end
  assign align_err = align_err_q;
`else
  assign align_err = 1'b0;
`endif
endmodule
